// File: rtl/joy_serial_decoder_pkg.sv
// Shared constants for the serial joystick decoder: button bit positions in the chain and scan FSM states.
// Latency: none (types and constants only); no backpressure.
package joy_pkg;

    localparam int JOY_UP    = 0;
    localparam int JOY_DOWN  = 1;
    localparam int JOY_LEFT  = 2;
    localparam int JOY_RIGHT = 3;
    localparam int JOY_FIRE1 = 4;
    localparam int JOY_FIRE2 = 5;
    localparam int JOY2_BASE = 8;

    localparam int JOY_NBTN  = 6;
    localparam int JOY_RAW_W = 2 * JOY_NBTN;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } joy_state_e;

endpackage

// File: rtl/joy_serial_decoder_if.sv
// Debounced button bus from the decoder to its consumer (kbd_joystick).
// Latency: wires only; no backpressure, the consumer samples on frame_o or at any time.
interface joy_serial_decoder_if;
    import joy_pkg::*;

    logic [JOY_NBTN-1:0] joy1_o;
    logic [JOY_NBTN-1:0] joy2_o;
    logic                frame_o;

    modport master (
        output joy1_o,
        output joy2_o,
        output frame_o
    );

    modport slave (
        input joy1_o,
        input joy2_o,
        input frame_o
    );

endinterface

// File: rtl/joy_serial_decoder_debounce.sv
// Frame-level debounce of the 12 raw button bits; buttons and frame pulse registered one clk after commit_i.
// No backpressure: a commit is always accepted.
module joy_debounce
    import joy_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic                 clk_i,
    input  logic                 res_n_i,
    input  logic                 commit_i,
    input  logic [JOY_RAW_W-1:0] raw_i,
    output logic [JOY_RAW_W-1:0] btn_o,
    output logic                 frame_o
);

    localparam logic [2:0] CNT_MAX = 3'(DEBOUNCE_FRAMES - 1);

    logic [JOY_RAW_W-1:0] prev_q, prev_d;
    logic [JOY_RAW_W-1:0] btn_q, btn_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 frame_q, frame_d;

    always_comb begin
        prev_d  = prev_q;
        btn_d   = btn_q;
        cnt_d   = cnt_q;
        frame_d = commit_i;
        if (commit_i) begin
            if (raw_i == prev_q) begin
                // Saturate so a long-held button keeps refreshing the outputs
                cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 3'd1;
                if (cnt_d == CNT_MAX) begin
                    btn_d = raw_i;
                end
            end else begin
                prev_d = raw_i;
                cnt_d  = 3'd0;
                if (DEBOUNCE_FRAMES == 1) begin
                    btn_d = raw_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!res_n_i) begin
            prev_q  <= '0;
            btn_q   <= '0;
            cnt_q   <= 3'd0;
            frame_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            btn_q   <= btn_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
        end
    end

    assign btn_o   = btn_q;
    assign frame_o = frame_q;

endmodule

// File: rtl/joy_serial_decoder.sv
// Scans a 74HC165-style joystick chain (load, then NBITS shift clocks) and debounces two 6-button pads.
// Frame period (2+2*NBITS-1)*CLK_DIV+1 clks; outputs update with frame_o; no backpressure.
module joy_serial_decoder
    import joy_pkg::*;
#(
    parameter int CLK_DIV         = 16,
    parameter int NBITS           = 16,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic                        clk_i,
    input  logic                        res_n_i,
    input  logic                        joy_data_i,
    output logic                        joy_clk_o,
    output logic                        joy_load_n_o,
    joy_serial_decoder_if.master        joy_if
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(NBITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

    joy_state_e        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [NBITS-1:0]  sreg_q, sreg_d;
    logic              jclk_q, jclk_d;
    logic              load_n_q, load_n_d;
    logic              tick;
    logic              commit;

    logic [JOY_RAW_W-1:0] raw;
    logic [JOY_RAW_W-1:0] btn;
    logic                 unused_sreg_bits;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        state_d  = state_q;
        div_d    = tick ? '0 : div_q + DIV_W'(1);
        bitcnt_d = bitcnt_q;
        sreg_d   = sreg_q;
        jclk_d   = jclk_q;
        load_n_d = load_n_q;
        commit   = 1'b0;
        unique case (state_q)
            LOAD: begin
                load_n_d = 1'b0;
                jclk_d   = 1'b1;
                // bitcnt doubles as the load tick counter; it is 0 on LOAD entry
                if (tick) begin
                    if (bitcnt_q[0]) begin
                        load_n_d = 1'b1;
                        bitcnt_d = '0;
                        state_d  = SHIFT;
                    end else begin
                        bitcnt_d = BIT_W'(1);
                    end
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (jclk_q) begin
                        sreg_d[bitcnt_q] = joy_data_i;
                        jclk_d           = 1'b0;
                        if (bitcnt_q == BIT_LAST) begin
                            state_d = COMMIT;
                        end
                    end else begin
                        jclk_d   = 1'b1;
                        bitcnt_d = bitcnt_q + BIT_W'(1);
                    end
                end
            end
            COMMIT: begin
                commit   = 1'b1;
                div_d    = '0;
                bitcnt_d = '0;
                load_n_d = 1'b0;
                jclk_d   = 1'b1;
                state_d  = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!res_n_i) begin
            state_q  <= LOAD;
            div_q    <= '0;
            bitcnt_q <= '0;
            sreg_q   <= '0;
            jclk_q   <= 1'b1;
            load_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bitcnt_q <= bitcnt_d;
            sreg_q   <= sreg_d;
            jclk_q   <= jclk_d;
            load_n_q <= load_n_d;
        end
    end

    // Chain buttons are active-low; bits 6, 7, 14 and 15 carry nothing useful
    always_comb begin
        raw = '0;
        for (int i = 0; i < JOY_NBTN; i++) begin
            raw[i]            = ~sreg_q[JOY_UP + i];
            raw[JOY_NBTN + i] = ~sreg_q[JOY2_BASE + i];
        end
    end

    assign unused_sreg_bits = ^sreg_q;

    joy_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk_i    (clk_i),
        .res_n_i  (res_n_i),
        .commit_i (commit),
        .raw_i    (raw),
        .btn_o    (btn),
        .frame_o  (joy_if.frame_o)
    );

    assign joy_if.joy1_o = btn[JOY_NBTN-1:0];
    assign joy_if.joy2_o = btn[JOY_RAW_W-1:JOY_NBTN];
    assign joy_clk_o     = jclk_q;
    assign joy_load_n_o  = load_n_q;

endmodule
